key_conditioner: RTL and testbench
==================================

# key_conditioner

Parametrised push-button front end for the Tetris board top: synchronises, debounces and edge-detects `width_p` raw key inputs, and optionally generates hold-to-repeat press pulses for selected channels. It runs entirely in the game clock domain. An internal tick divider replaces the separate 64 Hz sample clock and the cross-domain edge-detect register. Its outputs drive the `left`/`right`/`rotate`/`start`/`reset` request inputs of the game logic directly.

## Interface
- `width_p`, 5: number of key channels.
- `pos_valid_p`, 0: raw key polarity. 1 means pressed = high; 0 means pressed = low.
- `tick_div_p`, 781250: clock cycles per sample tick (64 Hz at 50 MHz). Must be ≥ 2.
- `stable_cnt_p`, 3: consecutive differing samples required to accept a level change. Must be ≥ 1.
- `repeat_delay_p`, 24: ticks from accepted press to the first repeat pulse. Must be ≥ 1.
- `repeat_rate_p`, 6: ticks between subsequent repeat pulses. Must be ≥ 1.
- `repeat_mask_p`, `'0`: `width_p`-bit mask. Bit i = 1 enables auto-repeat on channel i.
- `clk_i` in 1: the single clock.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `keys_i` in `width_p`: raw, asynchronous key pins.
- `level_o` out `width_p`: debounced key state, 1 = pressed, regardless of `pos_valid_p`.
- `press_o` out `width_p`: one-cycle pulse on each accepted press and on each repeat.
- `release_o` out `width_p`: one-cycle pulse on each accepted release.
- `tick_o` out 1: one-cycle pulse per sample tick, for the debug LED and the game timer.

## Operation
- **Synchroniser:** 2-flop synchroniser per channel. The result is normalised to active-high (inverted when `pos_valid_p` = 0).
- **Divider:** counter runs 0..`tick_div_p`-1 and wraps. `tick_q` is registered high for exactly one cycle when the count is `tick_div_p`-1.
- **Debounce**, per channel, evaluated only in cycles with `tick_q` = 1:
  - sample ≠ `level` → `stab_cnt`++.
  - When `stab_cnt` would reach `stable_cnt_p`: toggle `level` and clear `stab_cnt`.
  - sample = `level` → clear `stab_cnt`. Bounces therefore restart acceptance.
- **Pulses:**
  - Accepted 0→1: `press_o` pulse.
  - Accepted 1→0: `release_o` pulse.
- **Repeat FSM**, per channel, only where `repeat_mask_p[i]` = 1:
  - IDLE → DELAY on accepted press; `rpt_cnt` = `repeat_delay_p`.
  - DELAY / REPEAT: on each tick `rpt_cnt`--. On reaching 0: emit a `press_o` pulse, go to REPEAT, `rpt_cnt` = `repeat_rate_p`.
  - Any state → IDLE on accepted release, with no repeat pulse in that tick.
  - The initial press pulse and a repeat pulse cannot coincide; at most one `press_o` pulse per channel per tick.
- Unmasked channels stay in IDLE permanently.
- Channels are fully independent. Simultaneous presses on several channels pulse in the same cycle.
- **Widths:**
  - Counters are `$clog2(param+1)` bits.
  - Arithmetic is unsigned with no wrap. Comparisons happen before increment/decrement.

## Timing
- **Reset values:**
  - All outputs 0: `level_o`, `press_o`, `release_o`, `tick_o`.
  - Divider, `stab_cnt` and `rpt_cnt` are 0; all FSMs in IDLE.
  - Synchroniser flops reset to the released level.
- **Outputs:** all registered. Each pulse lasts exactly one cycle.
  - `press_o` / `release_o` assert in the same cycle `level_o` changes: the cycle after the `tick_q` cycle that accepted the change.
  - `tick_o` is `tick_q` delayed by one cycle, so it is aligned with those pulses.
- **Latency:** 2 cycles of synchronisation, then acceptance on the `stable_cnt_p`-th consecutive differing tick, then 1 output cycle.
- **Reset mid-operation:** everything clears immediately, with no pulses. A key held through reset produces a fresh `press_o` after the normal debounce once reset deasserts.
- **Glitch rejection:** glitches shorter than one tick period are never seen, or are seen in only one sample. With `stable_cnt_p` ≥ 2 they are rejected.

## Configuration
- **`KEY_COND_REPEAT_EN` defined:** the repeat FSMs and `rpt_cnt` are built as described above.
- **`KEY_COND_REPEAT_EN` undefined:**
  - No repeat logic is synthesised.
  - `repeat_delay_p`, `repeat_rate_p` and `repeat_mask_p` are ignored.
  - `press_o` pulses only on accepted press edges.

## Structure
- **Package `tetris` gains:**
  - `key_repeat_state_e`: IDLE, DELAY, REPEAT.
  - Channel index constants `KEY_START_IDX`=0, `KEY_ROTATE_IDX`=1, `KEY_RIGHT_IDX`=2, `KEY_LEFT_IDX`=3, `KEY_RESET_IDX`=4.
- **Sub-module `key_channel`:** one instance per channel, built with a generate loop. It contains the synchroniser, debounce counter, pulse registers and the repeat FSM.
- **Top `key_conditioner`:** holds the shared tick divider and the generate loop only.

## Test plan
All scenarios use `tick_div_p`=4, `stable_cnt_p`=3, `repeat_delay_p`=5, `repeat_rate_p`=2, `width_p`=5, `pos_valid_p`=0, `repeat_mask_p`=5'b01100.

1. **Clean press, `keys_i[0]` 1→0 held:** `level_o[0]` rises on the third tick after sync. There is one `press_o[0]` pulse aligned with `tick_o`, and no further pulses since ch0 is unmasked.
2. **Bounce, `keys_i[1]` low for 2 ticks, high for 1, low for 3:** exactly one `press_o[1]`, after the final 3-tick run. No `release_o[1]`.
3. **Auto-repeat, ch2 held for 20 ticks:** initial press; repeats 5 ticks later, then every 2 ticks (ticks +5, +7, +9, ...). Release stops pulses and gives one `release_o[2]`.
4. **Release during DELAY, ch3 released 3 ticks after acceptance:** no repeat pulse; one `release_o[3]`; FSM back in IDLE.
5. **Reset mid-hold, `reset_n_i` low for 2 cycles while ch2 is repeating:** all outputs 0 immediately. After deassert with the key still held, a fresh press follows 3 ticks later.
6. **`KEY_COND_REPEAT_EN` undefined, rerun scenario 3:** exactly one `press_o[2]` and one `release_o[2]`.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris board top.
// Holds the key channel index map and the repeat FSM state type.
package tetris;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } key_repeat_state_e;

    localparam int KEY_START_IDX  = 0;
    localparam int KEY_ROTATE_IDX = 1;
    localparam int KEY_RIGHT_IDX  = 2;
    localparam int KEY_LEFT_IDX   = 3;
    localparam int KEY_RESET_IDX  = 4;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One key channel: 2-flop synchroniser, tick-sampled debounce, press/release
// pulse registers and, with KEY_COND_REPEAT_EN defined, a hold-to-repeat FSM.
module key_channel
    import tetris::*;
#(
    parameter int unsigned pos_valid_p    = 0,
    parameter int unsigned stable_cnt_p   = 3,
    parameter int unsigned repeat_delay_p = 24,
    parameter int unsigned repeat_rate_p  = 6,
    parameter bit          repeat_en_p    = 1'b0
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic tick_i,
    input  logic key_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    // Raw pin level that means "not pressed"; the synchroniser resets to it.
    localparam logic REL_LVL = (pos_valid_p != 0) ? 1'b0 : 1'b1;
    localparam int   SW      = $clog2(stable_cnt_p + 1);

    logic          sync1_q, sync1_d, sync2_q, sync2_d;
    logic [SW-1:0] stab_cnt_q, stab_cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          sample, rise, fall, rpt_fire;

    assign sample = (pos_valid_p != 0) ? sync2_q : ~sync2_q;

    // Debounce: count consecutive differing samples, toggle on the last one.
    always_comb begin
        sync1_d    = key_i;
        sync2_d    = sync1_q;
        stab_cnt_d = stab_cnt_q;
        level_d    = level_q;
        rise       = 1'b0;
        fall       = 1'b0;
        if (tick_i) begin
            if (sample != level_q) begin
                if (stab_cnt_q == SW'(stable_cnt_p - 1)) begin
                    level_d    = ~level_q;
                    stab_cnt_d = '0;
                    rise       = ~level_q;
                    fall       = level_q;
                end else begin
                    stab_cnt_d = stab_cnt_q + SW'(1);
                end
            end else begin
                stab_cnt_d = '0;
            end
        end
        press_d   = rise | rpt_fire;
        release_d = fall;
    end

    // Synchroniser, debounce state and output pulse registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync1_q    <= REL_LVL;
            sync2_q    <= REL_LVL;
            stab_cnt_q <= '0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stab_cnt_q <= stab_cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
        end
    end

`ifdef KEY_COND_REPEAT_EN
    localparam int RW = $clog2(max2(repeat_delay_p, repeat_rate_p) + 1);

    key_repeat_state_e state_q, state_d;
    logic [RW-1:0]     rpt_cnt_q, rpt_cnt_d;

    // Repeat FSM: release wins over everything, a fresh press reloads the
    // delay, otherwise count down and fire when the count would hit zero.
    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        rpt_fire  = 1'b0;
        if (repeat_en_p && tick_i) begin
            if (fall) begin
                state_d   = IDLE;
                rpt_cnt_d = '0;
            end else if (rise) begin
                state_d   = DELAY;
                rpt_cnt_d = RW'(repeat_delay_p);
            end else if (state_q != IDLE) begin
                if (rpt_cnt_q <= RW'(1)) begin
                    rpt_fire  = 1'b1;
                    state_d   = REPEAT;
                    rpt_cnt_d = RW'(repeat_rate_p);
                end else begin
                    rpt_cnt_d = rpt_cnt_q - RW'(1);
                end
            end
        end
    end

    // Repeat FSM state register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            rpt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end
`else
    logic unused_rpt_cfg;
    assign unused_rpt_cfg = ^{32'(repeat_delay_p), 32'(repeat_rate_p), repeat_en_p};
    assign rpt_fire       = 1'b0;
`endif

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/key_conditioner.sv
// Push-button front end: shared sample-tick divider plus one key_channel per
// key. Auto-repeat on masked channels is built only with KEY_COND_REPEAT_EN.
module key_conditioner
    import tetris::*;
#(
    parameter int unsigned       width_p        = 5,
    parameter int unsigned       pos_valid_p    = 0,
    parameter int unsigned       tick_div_p     = 781250,
    parameter int unsigned       stable_cnt_p   = 3,
    parameter int unsigned       repeat_delay_p = 24,
    parameter int unsigned       repeat_rate_p  = 6,
    parameter logic [width_p-1:0] repeat_mask_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] keys_i,
    output logic [width_p-1:0] level_o,
    output logic [width_p-1:0] press_o,
    output logic [width_p-1:0] release_o,
    output logic               tick_o
);

    localparam int DW = $clog2(tick_div_p + 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          tick_q, tick_d;
    logic          tick_dly_q, tick_dly_d;

    // Divider wraps at tick_div_p-1 and flags that count as the sample tick.
    always_comb begin
        tick_d     = (div_cnt_q == DW'(tick_div_p - 1));
        div_cnt_d  = tick_d ? '0 : div_cnt_q + DW'(1);
        tick_dly_d = tick_q;
    end

    // Divider and tick registers; tick_o lags tick_q to line up with pulses.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            div_cnt_q  <= '0;
            tick_q     <= 1'b0;
            tick_dly_q <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            tick_q     <= tick_d;
            tick_dly_q <= tick_dly_d;
        end
    end

    assign tick_o = tick_dly_q;

    for (genvar i = 0; i < int'(width_p); i++) begin : g_ch
        key_channel #(
            .pos_valid_p   (pos_valid_p),
            .stable_cnt_p  (stable_cnt_p),
            .repeat_delay_p(repeat_delay_p),
            .repeat_rate_p (repeat_rate_p),
            .repeat_en_p   (repeat_mask_p[i])
        ) u_ch (
            .clk_i    (clk_i),
            .reset_n_i(reset_n_i),
            .tick_i   (tick_q),
            .key_i    (keys_i[i]),
            .level_o  (level_o[i]),
            .press_o  (press_o[i]),
            .release_o(release_o[i])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner (tick_div 4, stable 3, delay 5, rate 2,
// active-low keys, repeat on ch2/ch3). Repeat scenarios follow KEY_COND_REPEAT_EN.
module tb_key_conditioner;

    localparam int W = 5;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] keys  = '1;
    logic [W-1:0] level, press, rel;
    logic         tick;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int ch;
        int tk;
        bit rl;
    } ev_t;

    ev_t ev_q[$];
    int  tick_n   = 0;
    int  misalign = 0;

    always #5 clk = ~clk;

    key_conditioner #(
        .width_p       (W),
        .pos_valid_p   (0),
        .tick_div_p    (4),
        .stable_cnt_p  (3),
        .repeat_delay_p(5),
        .repeat_rate_p (2),
        .repeat_mask_p (5'b01100)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(rst_n),
        .keys_i   (keys),
        .level_o  (level),
        .press_o  (press),
        .release_o(rel),
        .tick_o   (tick)
    );

    // Event log: every pulse tagged with the tick_o index it coincides with.
    always @(negedge clk) begin
        if (tick) tick_n <= tick_n + 1;
        for (int i = 0; i < W; i++) begin
            if (press[i]) ev_q.push_back('{ch: i, tk: tick_n + (tick ? 1 : 0), rl: 1'b0});
            if (rel[i])   ev_q.push_back('{ch: i, tk: tick_n + (tick ? 1 : 0), rl: 1'b1});
        end
        if (((press | rel) != '0) && !tick) misalign <= misalign + 1;
    end

    function automatic int cnt_ev(input int start, input int ch, input bit rl);
        int n;
        n = 0;
        for (int k = start; k < ev_q.size(); k++)
            if (ev_q[k].ch == ch && ev_q[k].rl == rl) n++;
        return n;
    endfunction

    function automatic int nth_tk(input int start, input int ch, input bit rl, input int nth);
        int n;
        n = 0;
        for (int k = start; k < ev_q.size(); k++)
            if (ev_q[k].ch == ch && ev_q[k].rl == rl) begin
                if (n == nth) return ev_q[k].tk;
                n++;
            end
        return -1;
    endfunction

    // Advance to the n-th following tick_o cycle (sampled 1 ns after negedge).
    task automatic wait_ticks(input int n);
        int g;
        for (int t = 0; t < n; t++) begin
            g = 0;
            do begin
                @(negedge clk);
                #1;
                g++;
            end while (!tick && g < 16);
            if (!tick) begin
                checks++;
                failures++;
                $display("FAIL tick_timeout got=no tick want=tick within 16 cycles");
                return;
            end
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({level, press, rel, tick} !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", {level, press, rel, tick});
        end
        rst_n = 1'b1;
        wait_ticks(4);
        checks++;
        if (level !== 5'b0) begin
            failures++;
            $display("FAIL idle_level got=%b want=00000", level);
        end
        checks++;
        if (ev_q.size() != 0) begin
            failures++;
            $display("FAIL idle_no_pulses got=%0d want=0", ev_q.size());
        end
    endtask

    task automatic test_clean_press;
        int start, base;
        start = ev_q.size();
        base  = tick_n;
        keys[0] = 1'b0;
        wait_ticks(2);
        checks++;
        if (level[0] !== 1'b0) begin
            failures++;
            $display("FAIL clean_early_level got=%b want=0", level[0]);
        end
        wait_ticks(4);
        checks++;
        if (level[0] !== 1'b1) begin
            failures++;
            $display("FAIL clean_level got=%b want=1", level[0]);
        end
        checks++;
        if (cnt_ev(start, 0, 1'b0) != 1) begin
            failures++;
            $display("FAIL clean_press_count got=%0d want=1", cnt_ev(start, 0, 1'b0));
        end
        checks++;
        if (nth_tk(start, 0, 1'b0, 0) != base + 3) begin
            failures++;
            $display("FAIL clean_press_tick got=%0d want=%0d", nth_tk(start, 0, 1'b0, 0), base + 3);
        end
        start = ev_q.size();
        base  = tick_n;
        keys[0] = 1'b1;
        wait_ticks(5);
        checks++;
        if (level[0] !== 1'b0) begin
            failures++;
            $display("FAIL clean_rel_level got=%b want=0", level[0]);
        end
        checks++;
        if (cnt_ev(start, 0, 1'b1) != 1 || nth_tk(start, 0, 1'b1, 0) != base + 3) begin
            failures++;
            $display("FAIL clean_release got=%0d@%0d want=1@%0d",
                     cnt_ev(start, 0, 1'b1), nth_tk(start, 0, 1'b1, 0), base + 3);
        end
    endtask

    task automatic test_bounce;
        int start, base;
        start = ev_q.size();
        base  = tick_n;
        keys[1] = 1'b0;
        wait_ticks(2);
        keys[1] = 1'b1;
        wait_ticks(1);
        keys[1] = 1'b0;
        wait_ticks(6);
        checks++;
        if (cnt_ev(start, 1, 1'b0) != 1 || nth_tk(start, 1, 1'b0, 0) != base + 6) begin
            failures++;
            $display("FAIL bounce_press got=%0d@%0d want=1@%0d",
                     cnt_ev(start, 1, 1'b0), nth_tk(start, 1, 1'b0, 0), base + 6);
        end
        checks++;
        if (cnt_ev(start, 1, 1'b1) != 0) begin
            failures++;
            $display("FAIL bounce_release got=%0d want=0", cnt_ev(start, 1, 1'b1));
        end
        keys[1] = 1'b1;
        wait_ticks(5);
        checks++;
        if (level[1] !== 1'b0) begin
            failures++;
            $display("FAIL bounce_settle got=%b want=0", level[1]);
        end
    endtask

    task automatic test_simultaneous;
        int start, base;
        start = ev_q.size();
        base  = tick_n;
        keys[0] = 1'b0;
        keys[4] = 1'b0;
        wait_ticks(5);
        checks++;
        if (nth_tk(start, 0, 1'b0, 0) != base + 3 || nth_tk(start, 4, 1'b0, 0) != base + 3) begin
            failures++;
            $display("FAIL simul_press got=%0d,%0d want=%0d", nth_tk(start, 0, 1'b0, 0),
                     nth_tk(start, 4, 1'b0, 0), base + 3);
        end
        checks++;
        if (level !== 5'b10001) begin
            failures++;
            $display("FAIL simul_level got=%b want=10001", level);
        end
        keys = '1;
        wait_ticks(5);
    endtask

`ifdef KEY_COND_REPEAT_EN
    task automatic test_auto_repeat;
        int start, base;
        start = ev_q.size();
        base  = tick_n;
        keys[2] = 1'b0;
        wait_ticks(20);
        keys[2] = 1'b1;
        wait_ticks(10);
        checks++;
        if (cnt_ev(start, 2, 1'b0) != 9) begin
            failures++;
            $display("FAIL rpt_count got=%0d want=9", cnt_ev(start, 2, 1'b0));
        end
        checks++;
        if (nth_tk(start, 2, 1'b0, 0) != base + 3 || nth_tk(start, 2, 1'b0, 1) != base + 8 ||
            nth_tk(start, 2, 1'b0, 2) != base + 10 || nth_tk(start, 2, 1'b0, 8) != base + 22) begin
            failures++;
            $display("FAIL rpt_times got=%0d,%0d,%0d,%0d want=%0d,%0d,%0d,%0d",
                     nth_tk(start, 2, 1'b0, 0), nth_tk(start, 2, 1'b0, 1),
                     nth_tk(start, 2, 1'b0, 2), nth_tk(start, 2, 1'b0, 8),
                     base + 3, base + 8, base + 10, base + 22);
        end
        checks++;
        if (cnt_ev(start, 2, 1'b1) != 1 || nth_tk(start, 2, 1'b1, 0) != base + 23) begin
            failures++;
            $display("FAIL rpt_release got=%0d@%0d want=1@%0d",
                     cnt_ev(start, 2, 1'b1), nth_tk(start, 2, 1'b1, 0), base + 23);
        end
    endtask

    task automatic test_release_in_delay;
        int start, base;
        start = ev_q.size();
        base  = tick_n;
        keys[3] = 1'b0;
        wait_ticks(3);
        keys[3] = 1'b1;
        wait_ticks(9);
        checks++;
        if (cnt_ev(start, 3, 1'b0) != 1) begin
            failures++;
            $display("FAIL delay_rel_press got=%0d want=1", cnt_ev(start, 3, 1'b0));
        end
        checks++;
        if (cnt_ev(start, 3, 1'b1) != 1 || nth_tk(start, 3, 1'b1, 0) != base + 6) begin
            failures++;
            $display("FAIL delay_rel_release got=%0d@%0d want=1@%0d",
                     cnt_ev(start, 3, 1'b1), nth_tk(start, 3, 1'b1, 0), base + 6);
        end
        // A second press must run a full fresh delay from IDLE.
        start = ev_q.size();
        base  = tick_n;
        keys[3] = 1'b0;
        wait_ticks(7);
        keys[3] = 1'b1;
        wait_ticks(5);
        checks++;
        if (cnt_ev(start, 3, 1'b0) != 2 || nth_tk(start, 3, 1'b0, 1) != base + 8) begin
            failures++;
            $display("FAIL delay_idle_again got=%0d@%0d want=2@%0d",
                     cnt_ev(start, 3, 1'b0), nth_tk(start, 3, 1'b0, 1), base + 8);
        end
    endtask

    task automatic test_reset_mid_hold;
        int start, base;
        keys[2] = 1'b0;
        wait_ticks(10);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({level, press, rel, tick} !== 16'h0) begin
            failures++;
            $display("FAIL midreset_outputs got=%h want=0", {level, press, rel, tick});
        end
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        start = ev_q.size();
        base  = tick_n;
        wait_ticks(5);
        checks++;
        if (cnt_ev(start, 2, 1'b0) != 1 || nth_tk(start, 2, 1'b0, 0) != base + 3) begin
            failures++;
            $display("FAIL midreset_press got=%0d@%0d want=1@%0d",
                     cnt_ev(start, 2, 1'b0), nth_tk(start, 2, 1'b0, 0), base + 3);
        end
        keys[2] = 1'b1;
        wait_ticks(5);
        checks++;
        if (level !== 5'b0) begin
            failures++;
            $display("FAIL midreset_settle got=%b want=00000", level);
        end
    endtask
`else
    task automatic test_no_repeat;
        int start, base;
        start = ev_q.size();
        base  = tick_n;
        keys[2] = 1'b0;
        wait_ticks(20);
        keys[2] = 1'b1;
        wait_ticks(10);
        checks++;
        if (cnt_ev(start, 2, 1'b0) != 1 || nth_tk(start, 2, 1'b0, 0) != base + 3) begin
            failures++;
            $display("FAIL norpt_press got=%0d@%0d want=1@%0d",
                     cnt_ev(start, 2, 1'b0), nth_tk(start, 2, 1'b0, 0), base + 3);
        end
        checks++;
        if (cnt_ev(start, 2, 1'b1) != 1 || nth_tk(start, 2, 1'b1, 0) != base + 23) begin
            failures++;
            $display("FAIL norpt_release got=%0d@%0d want=1@%0d",
                     cnt_ev(start, 2, 1'b1), nth_tk(start, 2, 1'b1, 0), base + 23);
        end
    endtask
`endif

    task automatic test_alignment;
        checks++;
        if (misalign != 0) begin
            failures++;
            $display("FAIL pulse_alignment got=%0d want=0", misalign);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
`ifdef KEY_COND_REPEAT_EN
        test_auto_repeat();
        test_release_in_delay();
        test_reset_mid_hold();
`else
        test_no_repeat();
`endif
        test_alignment();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
